spi_multiport_master: RTL and testbench

- Parametrised SPI master serving NCH peripherals (flash, SD, expansion CS lines) from one shifter.
- Replaces the per-device SPI copies in the zxuno core: shared SCK/MOSI, per-channel active-low CS, MISO muxed by the selected channel.
- Adds a programmable SCK divider and a stretched activity output for the board test LED.
- Sits between the zxuno I/O port decoder and the board SPI pins.

---
 rtl/spi_multiport_pkg.sv | 30 +++
 rtl/spi_multiport_master_if.sv | 28 ++
 rtl/spi_activity_stretch.sv | 32 +++
 rtl/spi_multiport_master.sv | 191 +++++++++++++++++++
 tb/tb_spi_multiport_master.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_multiport_pkg.sv
// Shared definitions for the multi-channel SPI master.
// Contents:
//   spi_state_e : byte-engine FSM states (IDLE / LOW / HIGH / DONE)
//   clog2       : constant ceil(log2) helper used to size the SCK divider
//   CS_NONE     : all-ones chip-select pattern (no channel selected), sliced to NCH
package spi_multiport_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } spi_state_e;

    // Widest supported channel count is 16; callers slice to NCH bits.
    localparam logic [15:0] CS_NONE = 16'hFFFF;

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/spi_multiport_master_if.sv
// Host-side bus of the multi-channel SPI master (I/O port decoder <-> master).
// Signals:
//   cs_we, cs_wdata[NCH] : chip-select register write strobe and pattern (active-low bits)
//   start, tx_data[8]    : one-byte transfer request and the byte to send
//   busy                 : transfer in progress
//   rx_data[8], rx_valid : received byte and its one-cycle update pulse
// Modports: master = port decoder side, slave = SPI master side.
interface spi_multiport_master_if #(
    parameter int NCH = 4
);
    logic           cs_we;
    logic [NCH-1:0] cs_wdata;
    logic           start;
    logic [7:0]     tx_data;
    logic           busy;
    logic [7:0]     rx_data;
    logic           rx_valid;

    modport master (
        output cs_we, cs_wdata, start, tx_data,
        input  busy, rx_data, rx_valid
    );

    modport slave (
        input  cs_we, cs_wdata, start, tx_data,
        output busy, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_activity_stretch.sv
// Monostable for the board activity LED: every raw activity pulse keeps the
// output high for at least 2^(LEDW-1) clk cycles after raw activity ends.
// Ports:
//   clk, rst (sync, active-high)
//   raw      : unstretched activity (busy or any chip select asserted)
//   activity : stretched activity, ~MSB of the hold counter
// Instantiated only when SPI_ACTIVITY_STRETCH_EN is defined.
module spi_activity_stretch #(
    parameter int LEDW = 22
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic activity
);

    logic [LEDW-1:0] hold_cnt_r;

    // Hold counter: parked at all-ones, cleared by activity, counts up until the MSB sets.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_r <= {LEDW{1'b1}};
        end else if (raw) begin
            hold_cnt_r <= {LEDW{1'b0}};
        end else if (!hold_cnt_r[LEDW-1]) begin
            hold_cnt_r <= hold_cnt_r + {{(LEDW-1){1'b0}}, 1'b1};
        end
    end

    assign activity = ~hold_cnt_r[LEDW-1];

endmodule

// File: rtl/spi_multiport_master.sv
// Multi-channel SPI master (mode 0, MSB first) sharing one shifter, SCK and
// MOSI between NCH peripherals, each with its own active-low chip select.
// Ports:
//   clk, rst          : system clock, synchronous active-high reset
//   bus (slave)       : cs_we/cs_wdata, start/tx_data, busy, rx_data/rx_valid
//   spi_clk, spi_mosi : shared SCK (idle low) and MOSI (idle high)
//   spi_miso[NCH]     : per-channel MISO; lowest-index selected channel is used,
//                       reads 1 when nothing is selected
//   spi_cs_n[NCH]     : chip-select register, frozen while a byte is in flight
//   activity          : SPI-in-use indicator for the test LED
// Parameters: NCH (1..16), DIV (SCK half-period in clk cycles, >= 1),
//             LEDW (stretch counter width, used with the option below).
// Option: define SPI_ACTIVITY_STRETCH_EN to stretch activity with a monostable;
//         otherwise activity is the raw indicator delayed by one register.
module spi_multiport_master
    import spi_multiport_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int DIV  = 2,
    parameter int LEDW = 22
) (
    input  logic                    clk,
    input  logic                    rst,
    spi_multiport_master_if.slave   bus,
    output logic                    spi_clk,
    output logic                    spi_mosi,
    input  logic [NCH-1:0]          spi_miso,
    output logic [NCH-1:0]          spi_cs_n,
    output logic                    activity
);

    localparam int                 DIV_W    = clog2(DIV) + 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [NCH-1:0]     CS_IDLE  = CS_NONE[NCH-1:0];

    if (NCH < 1 || NCH > 16 || DIV < 1 || LEDW < 2) begin : g_bad_cfg
        $error("spi_multiport_master: parameter out of range");
    end

    spi_state_e       state_r;
    spi_state_e       state_next_s;
    logic [DIV_W-1:0] div_r;
    logic [2:0]       bit_r;
    logic [7:0]       shift_r;
    logic             sck_r;
    logic             mosi_r;
    logic             busy_r;
    logic [7:0]       rx_data_r;
    logic             rx_valid_r;
    logic [NCH-1:0]   cs_r;
    logic             miso_s;
    logic             half_done_s;
    logic             last_bit_s;
    logic             load_s;
    logic             rise_s;
    logic             fall_s;
    logic             finish_s;
    logic             activity_raw_s;

    assign half_done_s = (div_r == DIV_LAST);
    assign last_bit_s  = (bit_r == 3'd7);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = bus.start ? LOW : IDLE;
            LOW:     state_next_s = half_done_s ? HIGH : LOW;
            HIGH:    state_next_s = half_done_s ? (last_bit_s ? DONE : LOW) : HIGH;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // FSM outputs: one-cycle strobes that steer the datapath registers.
    always_comb begin
        load_s   = 1'b0;
        rise_s   = 1'b0;
        fall_s   = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            IDLE:    load_s   = bus.start;
            LOW:     rise_s   = half_done_s;
            HIGH:    fall_s   = half_done_s;
            DONE:    finish_s = 1'b1;
            default: load_s   = 1'b0;
        endcase
    end

    // MISO priority mux: scan downwards so the lowest selected index wins.
    always_comb begin
        miso_s = 1'b1;
        for (int i = NCH - 1; i >= 0; i--) begin
            miso_s = cs_r[i] ? miso_s : spi_miso[i];
        end
    end

    // Byte engine datapath: divider, shifter, SCK/MOSI and result registers.
    // MISO is shifted in at the rising edge, so after the shift shift_r[7]
    // already holds the next MOSI bit for the following falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r      <= {DIV_W{1'b0}};
            bit_r      <= 3'd0;
            shift_r    <= 8'h00;
            sck_r      <= 1'b0;
            mosi_r     <= 1'b1;
            busy_r     <= 1'b0;
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
        end else begin
            rx_valid_r <= finish_s;
            if (load_s) begin
                shift_r <= bus.tx_data;
                mosi_r  <= bus.tx_data[7];
                bit_r   <= 3'd0;
                div_r   <= {DIV_W{1'b0}};
                busy_r  <= 1'b1;
            end else if (rise_s) begin
                sck_r   <= 1'b1;
                shift_r <= {shift_r[6:0], miso_s};
                div_r   <= {DIV_W{1'b0}};
            end else if (fall_s) begin
                sck_r <= 1'b0;
                div_r <= {DIV_W{1'b0}};
                bit_r <= bit_r + 3'd1;
                if (!last_bit_s) begin
                    mosi_r <= shift_r[7];
                end
            end else if (finish_s) begin
                rx_data_r <= shift_r;
                busy_r    <= 1'b0;
                mosi_r    <= 1'b1;
            end else if (state_r == LOW || state_r == HIGH) begin
                div_r <= div_r + DIV_W'(1);
            end
        end
    end

    // Chip-select register; writes during a transfer are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_r <= CS_IDLE;
        end else if (bus.cs_we && !busy_r) begin
            cs_r <= bus.cs_wdata;
        end
    end

    assign activity_raw_s = busy_r | (cs_r != CS_IDLE);

`ifdef SPI_ACTIVITY_STRETCH_EN
    spi_activity_stretch #(
        .LEDW (LEDW)
    ) u_activity_stretch (
        .clk      (clk),
        .rst      (rst),
        .raw      (activity_raw_s),
        .activity (activity)
    );
`else
    logic activity_r;

    // Activity indicator: raw activity delayed by one register.
    always_ff @(posedge clk) begin
        if (rst) begin
            activity_r <= 1'b0;
        end else begin
            activity_r <= activity_raw_s;
        end
    end

    assign activity = activity_r;
`endif

    assign spi_clk      = sck_r;
    assign spi_mosi     = mosi_r;
    assign spi_cs_n     = cs_r;
    assign bus.busy     = busy_r;
    assign bus.rx_data  = rx_data_r;
    assign bus.rx_valid = rx_valid_r;

endmodule

// File: tb/tb_spi_multiport_master.sv
// Self-checking bench for spi_multiport_master (NCH=4, DIV=2, LEDW=6).
// Expected received bytes are queued when a transfer is issued; a monitor
// pops and compares on every rx_valid. Timing, MOSI order, CS and activity
// are checked directly by the stimulus process.
module tb_spi_multiport_master;

    localparam int NCH  = 4;
    localparam int DIV  = 2;
    localparam int LEDW = 6;
    localparam int LAT  = 16 * DIV + 1;
`ifdef SPI_ACTIVITY_STRETCH_EN
    localparam int ACT_HOLD = 32;
`else
    localparam int ACT_HOLD = 1;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           spi_clk;
    logic           spi_mosi;
    logic [NCH-1:0] spi_miso;
    logic [NCH-1:0] spi_cs_n;
    logic           activity;

    logic           loop_en;
    logic [7:0]     pat2;
    logic [7:0]     pat3;
    int             ridx = 0;
    int             rbase = 0;

    logic [7:0]     exp_q[$];
    int             n_checks = 0;
    int             n_fail = 0;

    always #5 clk = ~clk;

    spi_multiport_master_if #(.NCH(NCH)) bus ();

    spi_multiport_master #(
        .NCH  (NCH),
        .DIV  (DIV),
        .LEDW (LEDW)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_cs_n (spi_cs_n),
        .activity (activity)
    );

    function automatic logic bit_of(input logic [7:0] p, input int i);
        if (i >= 0 && i < 8) return p[7-i];
        return 1'b1;
    endfunction

    // Peripheral models: ch0 idle-high, ch1 loopback, ch2/ch3 serial patterns.
    assign spi_miso[0] = 1'b1;
    assign spi_miso[1] = loop_en ? spi_mosi : 1'b1;
    assign spi_miso[2] = bit_of(pat2, ridx - rbase);
    assign spi_miso[3] = bit_of(pat3, ridx - rbase);

    always @(posedge spi_clk) ridx <= ridx + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rx_valid: got rx_data %0h expected no rx_valid", bus.rx_data);
            end else begin
                check("rx_data", {24'h0, bus.rx_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic write_cs(input logic [NCH-1:0] v);
        bus.cs_we    = 1'b1;
        bus.cs_wdata = v;
        @(posedge clk); #1;
        bus.cs_we    = 1'b0;
    endtask

    // Runs one byte; optionally pulses start/cs_we at cycle inj (0 = never).
    task automatic run_byte(input logic [7:0] tx, input int inj, input logic [NCH-1:0] cs_exp,
                            output int lat, output logic [7:0] mosi_bits,
                            output int hi, output int rises, output int cs_bad);
        logic prev;
        lat = -1; mosi_bits = 8'h00; hi = 0; rises = 0; cs_bad = 0;
        bus.tx_data = tx;
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        prev = spi_clk;
        for (int k = 1; k <= 200; k++) begin
            if (k == inj) begin
                bus.start = 1'b1; bus.tx_data = 8'hFF;
                bus.cs_we = 1'b1; bus.cs_wdata = 4'b0000;
            end
            @(posedge clk); #1;
            bus.start = 1'b0; bus.cs_we = 1'b0;
            if (spi_clk && !prev) begin
                rises++;
                mosi_bits = {mosi_bits[6:0], spi_mosi};
            end
            if (spi_clk) hi++;
            if (spi_cs_n !== cs_exp) cs_bad++;
            prev = spi_clk;
            if (bus.rx_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat, hi, rises, cs_bad, k;
        logic [7:0] mb;

        rst = 1'b1; loop_en = 1'b0; pat2 = 8'hFF; pat3 = 8'hFF;
        bus.cs_we = 1'b0; bus.cs_wdata = 4'hF; bus.start = 1'b0; bus.tx_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_cs_n",     {28'h0, spi_cs_n}, 32'hF);
        check("reset_spi_clk",  {31'h0, spi_clk}, 32'h0);
        check("reset_mosi",     {31'h0, spi_mosi}, 32'h1);
        check("reset_busy",     {31'h0, bus.busy}, 32'h0);
        check("reset_rx_data",  {24'h0, bus.rx_data}, 32'h0);
        check("reset_rx_valid", {31'h0, bus.rx_valid}, 32'h0);
        check("reset_activity", {31'h0, activity}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Loopback on channel 1.
        write_cs(4'b1101);
        loop_en = 1'b1;
        exp_q.push_back(8'hA5);
        run_byte(8'hA5, 0, 4'b1101, lat, mb, hi, rises, cs_bad);
        check("loop_latency", lat, LAT);
        check("loop_sck_rises", rises, 8);
        check("loop_sck_high_cycles", hi, 8 * DIV);
        check("loop_mosi_bits", {24'h0, mb}, 32'hA5);
        check("loop_busy_done", {31'h0, bus.busy}, 32'h0);
        check("loop_cs_stable", cs_bad, 0);
        @(posedge clk); #1;

        // Activity after chip select is released.
        check("activity_while_selected", {31'h0, activity}, 32'h1);
        write_cs(4'b1111);
        check("activity_at_cs_release", {31'h0, activity}, 32'h1);
        k = 0;
        while (activity === 1'b1 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("activity_hold_cycles", k, ACT_HOLD);

        // No channel selected: MISO reads ones.
        loop_en = 1'b0;
        exp_q.push_back(8'hFF);
        run_byte(8'h3C, 0, 4'b1111, lat, mb, hi, rises, cs_bad);
        check("nosel_latency", lat, LAT);
        check("nosel_mosi_bits", {24'h0, mb}, 32'h3C);
        check("nosel_idle_mosi", {31'h0, spi_mosi}, 32'h1);
        @(posedge clk); #1;

        // Two channels selected: channel 2 wins over channel 3.
        write_cs(4'b0011);
        pat2 = 8'h5A; pat3 = 8'h00; rbase = ridx;
        exp_q.push_back(8'h5A);
        run_byte(8'hC3, 0, 4'b0011, lat, mb, hi, rises, cs_bad);
        check("multisel_latency", lat, LAT);
        check("multisel_mosi_bits", {24'h0, mb}, 32'hC3);
        @(posedge clk); #1;

        // Start and CS write mid-transfer are ignored.
        write_cs(4'b1101);
        loop_en = 1'b1;
        exp_q.push_back(8'h96);
        run_byte(8'h96, 10, 4'b1101, lat, mb, hi, rises, cs_bad);
        check("violation_latency", lat, LAT);
        check("violation_cs_stable", cs_bad, 0);
        repeat (60) @(posedge clk);
        #1;
        check("violation_cs_after", {28'h0, spi_cs_n}, 32'hD);
        check("violation_busy_after", {31'h0, bus.busy}, 32'h0);

        // Reset with a byte in flight: abort, no rx_valid.
        bus.tx_data = 8'h11; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("midreset_busy_before", {31'h0, bus.busy}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midreset_cs_n",    {28'h0, spi_cs_n}, 32'hF);
        check("midreset_spi_clk", {31'h0, spi_clk}, 32'h0);
        check("midreset_busy",    {31'h0, bus.busy}, 32'h0);
        check("midreset_mosi",    {31'h0, spi_mosi}, 32'h1);
        check("midreset_rx_data", {24'h0, bus.rx_data}, 32'h0A5 & 32'h0);
        repeat (60) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
